endgame_ctrl: RTL

Sequential end-of-match controller sitting directly upstream of the end-game banner renderer in the pong datapath. It counts points for both players, detects the winning score, freezes play, and drives the banner inputs: winner code, banner origin and blink-gated visibility. It slides the banner down from the top of the screen once per frame, blinks it, and re-arms the match on a restart press.

---
 rtl/endgame_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/endgame_ctrl.sv
// rtl/endgame_ctrl.sv - end-of-match controller: scoring, win detect, banner slide/blink, restart
module endgame_ctrl #(
  parameter int         WIN_SCORE    = 5,
  parameter logic [9:0] BANNER_X     = 10'd250,
  parameter logic [9:0] BANNER_Y0    = 10'd0,
  parameter logic [9:0] BANNER_Y     = 10'd200,
  parameter int         SLIDE_STEP   = 8,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       restart_btn,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] who_win,
  output logic       game_over,
  output logic       freeze,
  output logic [9:0] start_x,
  output logic [9:0] start_y,
  output logic       banner_on
);

  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [10:0] STEP       = 11'(SLIDE_STEP);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    SLIDE = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] score1_n, score2_n;
  logic [1:0] who_win_n;
  logic       game_over_n;
  logic [9:0] start_y_n;
  logic       banner_on_n;
  logic [7:0] blink_cnt, blink_n;
  logic       restart_q, restart_edge;
  logic [3:0] inc1, inc2;
  logic [10:0] slide_next;

  assign start_x    = BANNER_X;
  assign inc1       = score1 + 4'd1;
  assign inc2       = score2 + 4'd1;
  assign slide_next = {1'b0, start_y} + STEP;

  always_comb begin
    state_n     = state;
    score1_n    = score1;
    score2_n    = score2;
    who_win_n   = who_win;
    game_over_n = game_over;
    start_y_n   = start_y;
    banner_on_n = banner_on;
    blink_n     = blink_cnt;
    case (state)
      PLAY: begin
        // Simultaneous points cancel out; only a lone pulse scores.
        if (p1_point && !p2_point) begin
          score1_n = inc1;
          if (inc1 == WIN) begin
            who_win_n   = 2'd1;
            game_over_n = 1'b1;
            banner_on_n = 1'b1;
            start_y_n   = BANNER_Y0;
            state_n     = SLIDE;
          end
        end else if (p2_point && !p1_point) begin
          score2_n = inc2;
          if (inc2 == WIN) begin
            who_win_n   = 2'd2;
            game_over_n = 1'b1;
            banner_on_n = 1'b1;
            start_y_n   = BANNER_Y0;
            state_n     = SLIDE;
          end
        end
      end
      SLIDE: begin
        if (frame_tick) begin
          if (slide_next >= {1'b0, BANNER_Y}) begin
            start_y_n = BANNER_Y;
            blink_n   = 8'd0;
            state_n   = SHOW;
          end else begin
            start_y_n = slide_next[9:0];
          end
        end
      end
      SHOW: begin
        if (restart_edge) begin
          score1_n    = 4'd0;
          score2_n    = 4'd0;
          who_win_n   = 2'd0;
          game_over_n = 1'b0;
          banner_on_n = 1'b0;
          start_y_n   = BANNER_Y0;
          state_n     = PLAY;
        end else if (frame_tick) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_n     = 8'd0;
            banner_on_n = ~banner_on;
          end else begin
            blink_n = blink_cnt + 8'd1;
          end
        end
      end
      default: state_n = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PLAY;
      score1       <= 4'd0;
      score2       <= 4'd0;
      who_win      <= 2'd0;
      game_over    <= 1'b0;
      freeze       <= 1'b0;
      start_y      <= BANNER_Y0;
      banner_on    <= 1'b0;
      blink_cnt    <= 8'd0;
      restart_q    <= restart_btn;
      restart_edge <= 1'b0;
    end else begin
      state        <= state_n;
      score1       <= score1_n;
      score2       <= score2_n;
      who_win      <= who_win_n;
      game_over    <= game_over_n;
      freeze       <= game_over_n;
      start_y      <= start_y_n;
      banner_on    <= banner_on_n;
      blink_cnt    <= blink_n;
      // Edge detection runs everywhere; only SHOW consumes it, so earlier edges just expire.
      restart_q    <= restart_btn;
      restart_edge <= restart_btn & ~restart_q;
    end
  end

endmodule
